// File: rtl/param_serializer.sv
// Frame-to-beat serializer for the transmit path: loads up to MAX_BITS bits
// and emits them LANES bits per beat with valid/ready flow control.
module param_serializer #(
    parameter int MAX_BITS = 2400,
    parameter int LANES    = 1,
    parameter int LEN_W    = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [MAX_BITS-1:0]          in_data,
    input  logic [LEN_W-1:0]             in_len,
    input  logic                         in_msb_first,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [LANES-1:0]             out_data,
    output logic [$clog2(LANES+1)-1:0]   out_count,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    input  logic                         abort,
    output logic                         done
);

    localparam int CW = $clog2(LANES + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_d;
    logic                beat_acc, fin, accept;
    logic                load, adv, clear, done_d;
    logic [LEN_W-1:0]    eff_len, src_len, take, rem;
    logic [MAX_BITS-1:0] mask, rev_full, loaded, src, sh;

    always_comb begin
        beat_acc = out_valid && out_ready;
        fin      = (state == SEND) && beat_acc && out_last;
        in_ready = rst_n && !abort && ((state == IDLE) || fin);
        accept   = in_valid && in_ready;
    end

    // Reverse the whole word, then shift right so only the low L bits remain
    always_comb begin
        eff_len = (in_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : in_len;
        mask    = ~({MAX_BITS{1'b1}} << eff_len);
        for (int i = 0; i < MAX_BITS; i++) begin
            rev_full[i] = in_data[MAX_BITS-1-i];
        end
        if (in_msb_first) begin
            loaded = rev_full >> (LEN_W'(MAX_BITS) - eff_len);
        end else begin
            loaded = in_data & mask;
        end
    end

    always_comb begin
        src     = load ? loaded : sh;
        src_len = load ? eff_len : rem;
        take    = (src_len > LEN_W'(LANES)) ? LEN_W'(LANES) : src_len;
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        adv     = 1'b0;
        clear   = 1'b0;
        done_d  = 1'b0;
        if (state == SEND && abort) begin
            state_d = IDLE;
            clear   = 1'b1;
        end else if (accept) begin
            done_d = fin || (eff_len == '0);
            if (eff_len == '0) begin
                state_d = IDLE;
                clear   = 1'b1;
            end else begin
                state_d = SEND;
                load    = 1'b1;
            end
        end else if (fin) begin
            done_d  = 1'b1;
            state_d = IDLE;
            clear   = 1'b1;
        end else if (state == SEND && beat_acc) begin
            adv = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // sh holds only bits not yet placed on the output; bits above rem are 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            sh        <= '0;
            rem       <= '0;
        end else begin
            done <= done_d;
            if (clear) begin
                out_data  <= '0;
                out_count <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                sh        <= '0;
                rem       <= '0;
            end else if (load || adv) begin
                out_data  <= src[LANES-1:0];
                out_count <= take[CW-1:0];
                out_valid <= 1'b1;
                out_last  <= (src_len <= LEN_W'(LANES));
                sh        <= src >> LANES;
                rem       <= src_len - take;
            end
        end
    end

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer: one LANES=1 and one LANES=4 instance
// sharing clock and reset.
module tb_param_serializer;

    localparam int MB = 2400;
    localparam int LW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [MB-1:0] in_data1, in_data4;
    logic [LW-1:0] in_len1, in_len4;
    logic          msb1, msb4, in_valid1, in_valid4, in_ready1, in_ready4;
    logic [0:0]    out_data1;
    logic [3:0]    out_data4;
    logic [0:0]    out_count1;
    logic [2:0]    out_count4;
    logic          out_valid1, out_valid4, out_last1, out_last4;
    logic          out_ready1, out_ready4, abort1, abort4, done1, done4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_serializer #(.MAX_BITS(MB), .LANES(1), .LEN_W(LW)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data1), .in_len(in_len1), .in_msb_first(msb1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_count(out_count1),
        .out_valid(out_valid1), .out_last(out_last1),
        .out_ready(out_ready1), .abort(abort1), .done(done1)
    );

    param_serializer #(.MAX_BITS(MB), .LANES(4), .LEN_W(LW)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data4), .in_len(in_len4), .in_msb_first(msb4),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_count(out_count4),
        .out_valid(out_valid4), .out_last(out_last4),
        .out_ready(out_ready4), .abort(abort4), .done(done4)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accept edge
    task automatic offer(input int which, input logic [MB-1:0] d,
                         input logic [LW-1:0] len, input logic msb);
        int n;
        if (which == 1) begin
            in_data1 = d; in_len1 = len; msb1 = msb; in_valid1 = 1'b1;
        end else begin
            in_data4 = d; in_len4 = len; msb4 = msb; in_valid4 = 1'b1;
        end
        @(negedge clk);
        n = 0;
        while (((which == 1) ? !in_ready1 : !in_ready4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("offer_ready", (which == 1) ? in_ready1 : in_ready4, 1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] s1, s2;
        logic [3:0] e3 [3];
        logic [2:0] c3 [3];
        logic [3:0] e4 [3];
        logic [MB-1:0] big;
        int idx, dn, beats, ones, lastd;
        int v5 [5], d5 [5], o5 [5];

        in_data1 = '0; in_len1 = '0; msb1 = 0; in_valid1 = 0;
        in_data4 = '0; in_len4 = '0; msb4 = 0; in_valid4 = 0;
        out_ready1 = 1; out_ready4 = 1; abort1 = 0; abort4 = 0;

        #12;
        chk("rst_in_ready", in_ready1, 0);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_done", done1, 0);
        chk("rst_out_valid4", out_valid4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        @(negedge clk);
        chk("post_rst_ready", in_ready1, 1);
        chk("post_rst_ready4", in_ready4, 1);
        tick;

        // LSB-first 0b1011 and MSB-first of the same frame
        s1 = 4'b1011;
        s2 = 4'b1101;
        for (int pass = 0; pass < 2; pass++) begin
            offer(1, MB'(4'b1011), 12'd4, pass[0]);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("t1_valid", out_valid1, 1);
                chk("t1_data", out_data1, (pass == 0) ? s1[k] : s2[k]);
                chk("t1_last", out_last1, k == 3);
                chk("t1_ready", in_ready1, k == 3);
                chk("t1_done", done1, 0);
                tick;
            end
            @(negedge clk);
            chk("t1_done_pulse", done1, 1);
            chk("t1_idle", out_valid1, 0);
            tick;
            @(negedge clk);
            chk("t1_done_clr", done1, 0);
            tick;
        end

        // LANES=4, 10-bit frame 0x2A5
        e3[0] = 4'h5; e3[1] = 4'hA; e3[2] = 4'h2;
        c3[0] = 3'd4; c3[1] = 3'd4; c3[2] = 3'd2;
        offer(4, MB'(12'h2A5), 12'd10, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_valid", out_valid4, 1);
            chk("t3_data", out_data4, e3[k]);
            chk("t3_count", out_count4, c3[k]);
            chk("t3_last", out_last4, k == 2);
            tick;
        end
        @(negedge clk);
        chk("t3_done", done4, 1);
        tick;

        // Backpressure, MSB-first: bit sequence 1010 1001 01
        e4[0] = 4'h5; e4[1] = 4'h9; e4[2] = 4'h2;
        offer(4, MB'(12'h2A5), 12'd10, 1'b1);
        idx = 0;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready4 = (c % 3 == 0);
            @(negedge clk);
            if (done4) dn++;
            if (idx < 3) begin
                chk("t4_valid", out_valid4, 1);
                chk("t4_data", out_data4, e4[idx]);
                if (out_ready4) idx++;
            end else begin
                chk("t4_idle", out_valid4, 0);
            end
            tick;
        end
        out_ready4 = 1'b1;
        chk("t4_beats", idx, 3);
        chk("t4_done_once", dn, 1);

        // Back-to-back: A=01 then B=10, both LSB-first, 2 bits each
        v5 = '{1, 1, 1, 1, 0};
        d5 = '{1, 0, 0, 1, 0};
        o5 = '{0, 0, 1, 0, 1};
        offer(1, MB'(2'b01), 12'd2, 1'b0);
        in_data1 = MB'(2'b10);
        in_len1 = 12'd2;
        msb1 = 1'b0;
        in_valid1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_valid", out_valid1, v5[c]);
            chk("t5_data", out_data1, d5[c]);
            chk("t5_done", done1, o5[c]);
            if (c == 1) chk("t5_b2b_ready", in_ready1, 1);
            tick;
            if (c == 1) in_valid1 = 1'b0;
        end

        // Zero-length frame
        offer(1, MB'(4'hF), 12'd0, 1'b0);
        @(negedge clk);
        chk("t6_len0_done", done1, 1);
        chk("t6_len0_valid", out_valid1, 0);
        tick;
        @(negedge clk);
        chk("t6_len0_done_clr", done1, 0);
        chk("t6_len0_valid2", out_valid1, 0);
        tick;

        // Oversized length clamps to MAX_BITS
        big = '0;
        big[0] = 1'b1;
        big[MB-1] = 1'b1;
        offer(1, big, 12'd4000, 1'b0);
        beats = 0;
        ones = 0;
        lastd = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (out_valid1) begin
                beats++;
                ones += int'(out_data1);
                if (out_last1) begin
                    lastd = int'(out_data1);
                    break;
                end
            end
            tick;
        end
        chk("t6_clamp_beats", beats, MB);
        chk("t6_clamp_ones", ones, 2);
        chk("t6_clamp_lastbit", lastd, 1);
        tick;
        @(negedge clk);
        chk("t6_clamp_done", done1, 1);
        tick;

        // Abort mid-frame
        offer(1, MB'(4'b1011), 12'd4, 1'b0);
        @(negedge clk);
        chk("t6_ab_beat0", out_valid1, 1);
        tick;
        abort1 = 1'b1;
        @(negedge clk);
        chk("t6_ab_blocks", in_ready1, 0);
        tick;
        abort1 = 1'b0;
        @(negedge clk);
        chk("t6_ab_valid", out_valid1, 0);
        chk("t6_ab_last", out_last1, 0);
        chk("t6_ab_done", done1, 0);
        tick;
        @(negedge clk);
        chk("t6_ab_done2", done1, 0);
        chk("t6_ab_ready", in_ready1, 1);
        tick;

        // Reset mid-frame
        offer(1, MB'(4'b1111), 12'd4, 1'b0);
        @(negedge clk);
        chk("t6_rst_pre", out_valid1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid1, 0);
        chk("t6_rst_data", out_data1, 0);
        chk("t6_rst_last", out_last1, 0);
        chk("t6_rst_ready", in_ready1, 0);
        chk("t6_rst_done", done1, 0);
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rst_idle", out_valid1, 0);
        chk("t6_rst_nodone", done1, 0);
        chk("t6_rst_rdy", in_ready1, 1);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_serializer.md
Name: param_serializer

Overview:
- Next-generation bit serializer for the transmit path: accepts a frame of up to MAX_BITS bits with a per-frame length and emits it LANES bits per beat.
- Uses a valid/ready handshake on both sides, with output backpressure.
- Adds per-frame LSB/MSB-first order, a partial-last-beat lane count, a done pulse, abort, and back-to-back frame loading.
- Sits between the packet assembler and the line encoder/modulator.

Parameters:
- MAX_BITS, 2400: maximum frame length in bits; width of in_data.
- LANES, 1: bits emitted per output beat; must be 1..32 and divide MAX_BITS.
- LEN_W, 12: width of in_len; must satisfy 2^LEN_W > MAX_BITS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  MAX_BITS  frame payload; bit 0 is the LSB
- in_len  in  LEN_W  number of valid bits, starting at bit 0
- in_msb_first  in  1  0: send bit 0 first; 1: send bit in_len-1 first
- in_valid  in  1  frame offered
- in_ready  out  1  frame accepted when in_valid && in_ready at a rising edge
- out_data  out  LANES  beat payload; lane 0 is earliest in time
- out_count  out  $clog2(LANES+1)  number of valid lanes in this beat (1..LANES)
- out_valid  out  1  beat presented
- out_last  out  1  final beat of the frame
- out_ready  in  1  sink accepts the beat when out_valid && out_ready
- abort  in  1  synchronous cancel of the current frame
- done  out  1  one-cycle pulse after the last beat of a frame is accepted

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0 (in_ready=0 while in reset). in_ready=1 from the first clk after rst_n deasserts.
- States: IDLE, SEND.
- in_ready is combinational: (state==IDLE && !abort) || (state==SEND && out_valid && out_ready && out_last && !abort).
- Accept at edge N:
  - Latch effective length L = min(in_len, MAX_BITS) and the shift register.
  - If in_msb_first=1, bit-reverse the low L bits so the MSB is sent first.
  - Go to SEND. The first beat is registered and visible in cycle N+1; latency is 1 cycle.
- L=0: frame is accepted with no beats; done pulses at N+1; state stays IDLE.
- Beat contents:
  - Each beat carries the next min(LANES, remaining) bits.
  - Unused lanes on a partial last beat are driven 0; out_count gives the valid lane count.
  - out_last=1 exactly when remaining ≤ LANES.
- Output registers: out_data, out_count, out_valid and out_last hold stable while out_valid && !out_ready. The shift register and remaining-bit counter advance only on an accepted beat.
- No bubbles: with out_ready held at 1, beats are emitted every cycle; a frame takes ceil(L/LANES) cycles.
- Last beat accepted:
  - done=1 in the next cycle.
  - If a new frame is accepted in the same cycle (back-to-back), its first beat appears in the next cycle with no idle gap. Otherwise go to IDLE with out_valid=0.
- abort=1 in SEND: next cycle state=IDLE, out_valid=0, out_last=0; no done pulse. abort takes priority over a simultaneous in_valid and over a simultaneous last-beat accept. abort in IDLE has no effect other than blocking acceptance that cycle.
- The remaining-bit counter is LEN_W wide and never underflows; it saturates at 0 in IDLE.
- in_data, in_len and in_msb_first are sampled only at acceptance; later changes have no effect on the frame in flight.
- Inputs are synchronous to clk. rst_n asserted mid-frame drops the frame immediately with no done pulse.

Test Plan:
1. LANES=1, in_data=0b1011, in_len=4, msb_first=0, out_ready=1:
   - out_data sequence 1,1,0,1 in cycles N+1..N+4.
   - out_last in cycle N+4; done in cycle N+5.
   - in_ready=0 in cycles N+1..N+3.
2. Same frame with msb_first=1:
   - sequence 1,0,1,1.
3. LANES=4, in_len=10, in_data=0x2A5:
   - beats 0x5 (count 4), 0xA (count 4), then 0x2 (count 2, last, upper lanes 0).
4. Backpressure: out_ready toggled 1,0,0,1,...:
   - out_data holds during stalls; no bits lost or repeated; total beat count ceil(L/LANES).
5. Back-to-back: second frame held valid during the first frame's last beat:
   - accepted in the same cycle; no gap in out_valid; done pulses once per frame.
6. Edge cases:
   - in_len=0 → no beats, done pulse.
   - in_len=4000 → clamped to 2400 beats (LANES=1).
   - abort mid-frame → out_valid=0 next cycle, no done.
   - rst_n pulsed mid-frame → all outputs 0 immediately.
